// File: rtl/key_press_controller_if.sv
// Purpose: key controller boundary: raw key, enable, press pulses, busy and press count.
// Latency: none (wires only).
// Backpressure: none; the pulses are fire-and-forget, so the consumer must sample every cycle.
interface key_press_controller_if #(
    parameter int PCNT_WIDTH = 8
);
    logic                  key_in;
    logic                  enable;
    logic                  short_press;
    logic                  long_press;
    logic                  busy;
    logic [PCNT_WIDTH-1:0] press_count;

    // Driven by the board / user logic side.
    modport master (
        output key_in,
        output enable,
        input  short_press,
        input  long_press,
        input  busy,
        input  press_count
    );

    // Driven by the controller.
    modport slave (
        input  key_in,
        input  enable,
        output short_press,
        output long_press,
        output busy,
        output press_count
    );
endinterface

// File: rtl/key_press_controller.sv
// Purpose: debounce one active-low key and classify each press as a short or long one-cycle pulse.
// Latency: 2-cycle sync + DEB_CYCLES confirm; pulses are registered (1 cycle after decision).
// Backpressure: none; the pulses are fire-and-forget, and enable=0 forces IDLE without emitting any pulse.
module key_press_controller #(
    parameter int DEB_CYCLES  = 20,
    parameter int LONG_CYCLES = 100,
    parameter int CNT_WIDTH   = 16,
    parameter int PCNT_WIDTH  = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    key_press_controller_if.slave   kif
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEB_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

    state_t                 state_q, state_d;
    logic                   sync1_q, key_s_q, key_d_q;
    logic [CNT_WIDTH-1:0]   deb_cnt_q, deb_cnt_d;
    logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;
    logic                   long_flag_q, long_flag_d;
    logic                   short_q, short_d;
    logic                   long_q, long_d;
    logic                   busy_q, busy_d;
    logic [PCNT_WIDTH-1:0]  pcnt_q, pcnt_d;

    logic fall;
    logic in_hold;
    logic long_trig;
    logic deb_done;

    // Reset value 1 (released key), so leaving reset never looks like a falling edge.
    assign fall      = key_d_q & ~key_s_q;
    assign in_hold   = (state_q == PRESSED) || (state_q == DEB_REL);
    assign long_trig = in_hold && (hold_cnt_q == LONG_LAST) && !long_flag_q;
    assign deb_done  = (deb_cnt_q == DEB_LAST);
    assign hold_inc  = (hold_cnt_q == LONG_LAST) ? hold_cnt_q : hold_cnt_q + CNT_WIDTH'(1);

    // Two-flop synchroniser for the asynchronous key, plus one delay stage for edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
            key_d_q <= 1'b1;
        end else begin
            sync1_q <= kif.key_in;
            key_s_q <= sync1_q;
            key_d_q <= key_s_q;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped enable overrides every transition.
    always_comb begin
        state_d = state_q;
        if (!kif.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (fall) state_d = DEB_PRESS;
                DEB_PRESS: begin
                    if (key_s_q)       state_d = IDLE;
                    else if (deb_done) state_d = PRESSED;
                end
                PRESSED:   if (key_s_q) state_d = DEB_REL;
                DEB_REL: begin
                    if (!key_s_q)      state_d = PRESSED;
                    else if (deb_done) state_d = IDLE;
                end
                default:   state_d = IDLE;
            endcase
        end
    end

    // Counter, flag and pulse next values for the current state.
    always_comb begin
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        pcnt_d      = pcnt_q;
        if (!kif.enable) begin
            deb_cnt_d   = '0;
            hold_cnt_d  = '0;
            long_flag_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: deb_cnt_d = '0;
                DEB_PRESS: begin
                    if (!key_s_q) begin
                        if (deb_done) begin
                            hold_cnt_d  = '0;
                            long_flag_d = 1'b0;
                            pcnt_d      = pcnt_q + PCNT_WIDTH'(1);
                        end else begin
                            deb_cnt_d = deb_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                PRESSED: begin
                    hold_cnt_d = hold_inc;
                    if (key_s_q) deb_cnt_d = '0;
                end
                DEB_REL: begin
                    hold_cnt_d = hold_inc;
                    if (!key_s_q) begin
                        deb_cnt_d = '0;
                    end else if (deb_done) begin
                        // A long press decided this very cycle suppresses the short pulse.
                        short_d = !long_flag_q && !long_trig;
                    end else begin
                        deb_cnt_d = deb_cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: deb_cnt_d = '0;
            endcase
            if (long_trig) begin
                long_d      = 1'b1;
                long_flag_d = 1'b1;
            end
        end
    end

    assign busy_d = (state_d != IDLE);

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            busy_q      <= 1'b0;
            pcnt_q      <= '0;
        end else begin
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            short_q     <= short_d;
            long_q      <= long_d;
            busy_q      <= busy_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign kif.short_press = short_q;
    assign kif.long_press  = long_q;
    assign kif.busy        = busy_q;
    assign kif.press_count = pcnt_q;
endmodule

// File: tb/tb_key_press_controller.sv
// Purpose: directed checks of key_press_controller with DEB_CYCLES=4, LONG_CYCLES=16.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: none; the pulses are fire-and-forget, so every fixed-length sequence is sampled each cycle.
module tb_key_press_controller;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    key_press_controller_if #(.PCNT_WIDTH(8)) kif ();

    key_press_controller #(
        .DEB_CYCLES (4),
        .LONG_CYCLES(16),
        .CNT_WIDTH  (16),
        .PCNT_WIDTH (8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .kif(kif)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Running pulse monitor sampled on the falling edge.
    int        n_short = 0;
    int        n_long  = 0;
    int        cyc     = 0;
    int        l_cyc   = 0;
    int        p_cyc   = 0;
    logic [7:0] prev_p = 8'd0;
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (kif.short_press === 1'b1) n_short = n_short + 1;
        if (kif.long_press === 1'b1) begin
            n_long = n_long + 1;
            l_cyc  = cyc;
        end
        if (kif.press_count !== prev_p) begin
            prev_p = kif.press_count;
            p_cyc  = cyc;
        end
    end

    typedef struct {
        logic       k;
        logic       e;
        logic       s;
        logic       l;
        logic       b;
        logic [7:0] p;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step(input logic k, input logic e);
        kif.key_in = k;
        kif.enable = e;
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input int low_n, input int high_n);
        for (int i = 0; i < low_n; i++)  step(1'b0, 1'b1);
        for (int i = 0; i < high_n; i++) step(1'b1, 1'b1);
    endtask

    int s0, l0, busy_seen;
    int exp_pcnt;

    initial begin
        kif.key_in = 1'b1;
        kif.enable = 1'b1;
        exp_pcnt   = 0;

        // Clean press trace: 10 low, 10 high; row i is sampled after edge i+1.
        for (int i = 0; i < 20; i++) begin
            tbl[i].k = (i < 10) ? 1'b0 : 1'b1;
            tbl[i].e = 1'b1;
            tbl[i].s = (i == 16);
            tbl[i].l = 1'b0;
            tbl[i].b = (i >= 2 && i <= 15);
            tbl[i].p = (i >= 6) ? 8'd1 : 8'd0;
        end

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_short", int'(kif.short_press), 0);
        chk("reset_long",  int'(kif.long_press), 0);
        chk("reset_busy",  int'(kif.busy), 0);
        chk("reset_pcnt",  int'(kif.press_count), 0);
        RST = 1'b1;
        repeat (3) step(1'b1, 1'b1);

        // Table-driven clean press.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].k, tbl[i].e);
            chk($sformatf("clean_short[%0d]", i), int'(kif.short_press), int'(tbl[i].s));
            chk($sformatf("clean_long[%0d]", i),  int'(kif.long_press),  int'(tbl[i].l));
            chk($sformatf("clean_busy[%0d]", i),  int'(kif.busy),        int'(tbl[i].b));
            chk($sformatf("clean_pcnt[%0d]", i),  int'(kif.press_count), int'(tbl[i].p));
        end
        exp_pcnt = 1;

        // Long hold: one long pulse 16 clocks after press confirm, silent release.
        s0 = n_short; l0 = n_long;
        press(30, 15);
        exp_pcnt = exp_pcnt + 1;
        chk("long_cnt",   n_long - l0, 1);
        chk("long_short", n_short - s0, 0);
        chk("long_lat",   l_cyc - p_cyc, 16);
        chk("long_pcnt",  int'(kif.press_count), exp_pcnt);
        chk("long_busy",  int'(kif.busy), 0);

        // Press bounce: low 2, high 1, low 2, high.
        s0 = n_short; l0 = n_long;
        press(2, 1);
        press(2, 12);
        chk("pbounce_short", n_short - s0, 0);
        chk("pbounce_long",  n_long - l0, 0);
        chk("pbounce_pcnt",  int'(kif.press_count), exp_pcnt);
        chk("pbounce_busy",  int'(kif.busy), 0);

        // Release bounce: low 10, high 2, low 2, high 10 -> short at edge 21.
        s0 = n_short; l0 = n_long;
        press(10, 2);
        press(2, 6);
        chk("rbounce_early", n_short - s0, 0);
        step(1'b1, 1'b1);
        chk("rbounce_pulse", int'(kif.short_press), 1);
        press(0, 3);
        exp_pcnt = exp_pcnt + 1;
        chk("rbounce_short", n_short - s0, 1);
        chk("rbounce_long",  n_long - l0, 0);
        chk("rbounce_pcnt",  int'(kif.press_count), exp_pcnt);

        // Enable drop in PRESSED at hold_cnt = 8, key kept low across re-enable.
        s0 = n_short; l0 = n_long;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        exp_pcnt = exp_pcnt + 1;
        chk("en_pre_busy", int'(kif.busy), 1);
        step(1'b0, 1'b0);
        chk("en_drop_busy", int'(kif.busy), 0);
        chk("en_drop_pcnt", int'(kif.press_count), exp_pcnt);
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1);
            if (kif.busy === 1'b1) busy_seen = busy_seen + 1;
        end
        chk("en_held_busy", busy_seen, 0);
        chk("en_held_pulses", (n_short - s0) + (n_long - l0), 0);
        chk("en_held_pcnt", int'(kif.press_count), exp_pcnt);
        press(0, 5);
        press(10, 10);
        exp_pcnt = exp_pcnt + 1;
        chk("en_repress_pcnt",  int'(kif.press_count), exp_pcnt);
        chk("en_repress_short", n_short - s0, 1);

        // Async reset in DEB_REL: outputs clear at once, no pulse afterwards.
        press(10, 4);
        chk("rst_pre_busy", int'(kif.busy), 1);
        RST = 1'b0;
        #1;
        chk("rst_busy",  int'(kif.busy), 0);
        chk("rst_pcnt",  int'(kif.press_count), 0);
        chk("rst_short", int'(kif.short_press), 0);
        chk("rst_long",  int'(kif.long_press), 0);
        s0 = n_short; l0 = n_long;
        step(1'b1, 1'b1);
        RST = 1'b1;
        press(0, 10);
        chk("rst_after_pulses", (n_short - s0) + (n_long - l0), 0);
        chk("rst_after_busy", int'(kif.busy), 0);

        // Wrap: 256 clean presses from zero.
        s0 = n_short;
        for (int n = 0; n < 255; n++) press(10, 10);
        chk("wrap_255", int'(kif.press_count), 255);
        press(10, 10);
        chk("wrap_0", int'(kif.press_count), 0);
        chk("wrap_shorts", n_short - s0, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
